// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - zero-latency instruction memory responder with burst program-load port
// Fetch reads are combinational; the load FSM writes one word per accepted load beat.
module imem_responder #(
   parameter int unsigned    DEPTH     = 256,
   parameter logic [31:0]    BASE_ADDR = 32'h0,
   localparam int unsigned   AW        = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          imemreq_val_i,
   input  logic [31:0]   imemreq_addr_i,
   output logic [31:0]   imemresp_data_o,
   input  logic          load_start_i,
   input  logic [AW-1:0] load_base_i,
   input  logic [AW:0]   load_len_i,
   input  logic          load_val_i,
   input  logic [31:0]   load_data_i,
   output logic          load_rdy_o,
   output logic          load_busy_o,
   output logic          load_done_o,
   output logic          err_misalign_o,
   output logic          err_range_o,
   output logic [31:0]   req_count_o
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t        state_q;
   logic [AW-1:0] ptr_q;
   logic [AW:0]   cnt_q;
   logic          rdy_q, busy_q, done_q;
   logic          err_misalign_q, err_misalign_d;
   logic          err_range_q, err_range_d;
   logic [31:0]   req_count_q, req_count_d;
   logic [31:0]   mem_q [DEPTH];

   // 33-bit subtract: bit 32 is the borrow, i.e. the address lies below BASE_ADDR.
   logic [32:0]   off_ext;
   logic [31:0]   off;
   logic          below, above, aligned, hit;
   logic [AW-1:0] rd_idx;
   logic          wr_en;

   assign off_ext = {1'b0, imemreq_addr_i} - {1'b0, BASE_ADDR};
   assign off     = off_ext[31:0];
   assign below   = off_ext[32];
   assign above   = {2'b00, off} >= (34'(DEPTH) << 2);
   assign aligned = (imemreq_addr_i[1:0] == 2'b00);
   assign hit     = imemreq_val_i && aligned && !below && !above;
   assign rd_idx  = off[AW+1:2];

   assign imemresp_data_o = hit ? mem_q[rd_idx] : 32'h0;

   assign wr_en = (state_q == S_LOAD) && load_val_i && !rst_i;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[ptr_q] <= load_data_i;
      end
   end

   always_comb begin
      err_misalign_d = err_misalign_q;
      err_range_d    = err_range_q;
      req_count_d    = req_count_q;
      if (imemreq_val_i) begin
         if (!aligned)        err_misalign_d = 1'b1;
         if (below || above)  err_range_d    = 1'b1;
         if (req_count_q != 32'hFFFF_FFFF) req_count_d = req_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_misalign_q <= 1'b0;
         err_range_q    <= 1'b0;
         req_count_q    <= 32'h0;
      end else begin
         err_misalign_q <= err_misalign_d;
         err_range_q    <= err_range_d;
         req_count_q    <= req_count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_start_i) begin
                  ptr_q  <= load_base_i;
                  cnt_q  <= load_len_i;
                  busy_q <= 1'b1;
                  if (load_len_i != '0) begin
                     state_q <= S_LOAD;
                     rdy_q   <= 1'b1;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (load_val_i) begin
                  ptr_q <= ptr_q + 1'b1;
                  cnt_q <= cnt_q - (AW+1)'(1);
                  if (cnt_q == (AW+1)'(1)) begin
                     state_q <= S_DONE;
                     rdy_q   <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               rdy_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_rdy_o     = rdy_q;
   assign load_busy_o    = busy_q;
   assign load_done_o    = done_q;
   assign err_misalign_o = err_misalign_q;
   assign err_range_o    = err_range_q;
   assign req_count_o    = req_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
// Fetch expectations are queued by stimulus and consumed by the negedge monitor.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemreq_val;
   logic [31:0] imemreq_addr;
   logic [31:0] imemresp_data;
   logic        load_start;
   logic [7:0]  load_base;
   logic [8:0]  load_len;
   logic        load_val;
   logic [31:0] load_data;
   logic        load_rdy, load_busy, load_done;
   logic        err_misalign, err_range;
   logic [31:0] req_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned exp_req  = 0;
   logic [31:0] exp_q [$];
   logic [31:0] ld_data [8];

   always #5 clk = ~clk;

   imem_responder #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
      .clk_i(clk), .rst_i(rst),
      .imemreq_val_i(imemreq_val), .imemreq_addr_i(imemreq_addr),
      .imemresp_data_o(imemresp_data),
      .load_start_i(load_start), .load_base_i(load_base), .load_len_i(load_len),
      .load_val_i(load_val), .load_data_i(load_data),
      .load_rdy_o(load_rdy), .load_busy_o(load_busy), .load_done_o(load_done),
      .err_misalign_o(err_misalign), .err_range_o(err_range),
      .req_count_o(req_count)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && imemreq_val) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fetch_unexpected: got %h expected no fetch", imemresp_data);
         end else begin
            chk("fetch_data", imemresp_data, exp_q.pop_front());
         end
      end
   end

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
      imemreq_val  = 1'b1;
      imemreq_addr = addr;
      exp_q.push_back(exp);
      exp_req++;
      @(posedge clk); #1;
      imemreq_val = 1'b0;
   endtask

   task automatic ctl(input string tag, input logic rdy, input logic busy, input logic done);
      chk({tag, "_rdy"},  32'(load_rdy),  32'(rdy));
      chk({tag, "_busy"}, 32'(load_busy), 32'(busy));
      chk({tag, "_done"}, 32'(load_done), 32'(done));
   endtask

   // gap inserts an idle beat before each word after the first; abort_at asserts rst
   // (with a live load beat) instead of the word of that index.
   task automatic do_load(input int base, input int len, input bit gap, input int abort_at,
                          input bit stray, input bit conc, input logic [31:0] conc_addr,
                          input logic [31:0] conc_exp);
      load_start = 1'b1;
      load_base  = 8'(base);
      load_len   = 9'(len);
      @(negedge clk);
      chk("start_rdy", 32'(load_rdy), 32'd0);
      @(posedge clk); #1;
      load_start = 1'b0;
      if (len == 0) begin
         @(negedge clk); ctl("len0_done", 1'b0, 1'b1, 1'b1);
         @(posedge clk); #1;
         @(negedge clk); ctl("len0_idle", 1'b0, 1'b0, 1'b0);
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (i == abort_at) begin
            rst = 1'b1; load_val = 1'b1; load_data = ld_data[i];
            @(posedge clk); #1;
            rst = 1'b0; load_val = 1'b0;
            return;
         end
         if (gap && i > 0) begin
            load_val = 1'b0; load_start = stray;
            @(negedge clk); ctl("gap", 1'b1, 1'b1, 1'b0);
            @(posedge clk); #1;
         end
         load_val   = 1'b1;
         load_data  = ld_data[i];
         load_start = stray;
         if (stray) begin
            load_base = 8'd1;
            load_len  = 9'd5;
         end
         if (conc) begin
            imemreq_val  = 1'b1;
            imemreq_addr = conc_addr;
            exp_q.push_back(conc_exp);
            exp_req++;
         end
         @(negedge clk); ctl("load", 1'b1, 1'b1, 1'b0);
         @(posedge clk); #1;
         load_val = 1'b0; load_start = 1'b0; imemreq_val = 1'b0;
      end
      @(negedge clk); ctl("done", 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk); ctl("idle", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic flags(input string tag, input logic mis, input logic rng);
      @(negedge clk);
      chk({tag, "_misalign"}, 32'(err_misalign), 32'(mis));
      chk({tag, "_range"},    32'(err_range),    32'(rng));
      chk({tag, "_req_count"}, req_count, exp_req);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; imemreq_val = 1'b0; imemreq_addr = '0;
      load_start = 1'b0; load_base = '0; load_len = '0; load_val = 1'b0; load_data = '0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      @(negedge clk); ctl("reset", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      flags("reset", 1'b0, 1'b0);

      // 1: back-to-back load then readback
      ld_data[0] = 32'h11; ld_data[1] = 32'h22; ld_data[2] = 32'h33; ld_data[3] = 32'h44;
      do_load(0, 4, 1'b0, 99, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch(32'h0, 32'h11); fetch(32'h4, 32'h22); fetch(32'h8, 32'h33); fetch(32'hC, 32'h44);

      // 2: load with val toggling 1,0,1,0,1
      ld_data[0] = 32'hA1; ld_data[1] = 32'hA2; ld_data[2] = 32'hA3;
      do_load(8, 3, 1'b1, 99, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch(32'h20, 32'hA1); fetch(32'h24, 32'hA2); fetch(32'h28, 32'hA3);

      // 3: pointer wrap, stray load_start during LOAD
      ld_data[0] = 32'hAAAA; ld_data[1] = 32'hBBBB;
      do_load(255, 2, 1'b0, 99, 1'b1, 1'b0, 32'h0, 32'h0);
      fetch(32'h3FC, 32'hAAAA); fetch(32'h0, 32'hBBBB); fetch(32'h4, 32'h22);

      // 4: error flags are sticky until reset
      fetch(32'h402, 32'h0);
      flags("bad402", 1'b1, 1'b1);
      fetch(32'h8, 32'h33);
      flags("sticky", 1'b1, 1'b1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; exp_req = 0;
      flags("cleared", 1'b0, 1'b0);
      fetch(32'h3, 32'h0);
      flags("mis_only", 1'b1, 1'b0);
      fetch(32'h400, 32'h0);
      flags("range_hit", 1'b1, 1'b1);
      fetch(32'h3FC, 32'hAAAA);

      // 5: read-during-write returns the old word; zero-length load
      ld_data[0] = 32'h5A5A;
      do_load(5, 1, 1'b0, 99, 1'b0, 1'b0, 32'h0, 32'h0);
      ld_data[0] = 32'hC3C3;
      do_load(5, 1, 1'b0, 99, 1'b0, 1'b1, 32'h14, 32'h5A5A);
      fetch(32'h14, 32'hC3C3);
      do_load(9, 0, 1'b0, 99, 1'b0, 1'b0, 32'h0, 32'h0);
      fetch(32'h24, 32'hA2);

      // 6: reset mid-load after two words
      fetch(32'h4, 32'h22);
      ld_data[0] = 32'hD0; ld_data[1] = 32'hD1; ld_data[2] = 32'hD2; ld_data[3] = 32'hD3;
      do_load(0, 4, 1'b0, 2, 1'b0, 1'b0, 32'h0, 32'h0);
      exp_req = 0;
      @(negedge clk); ctl("abort", 1'b0, 1'b0, 1'b0);
      chk("abort_req_count", req_count, 32'h0);
      @(posedge clk); #1;
      fetch(32'h0, 32'hD0); fetch(32'h4, 32'hD1); fetch(32'h8, 32'h33); fetch(32'hC, 32'h44);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
